// File: rtl/fp_simd_sequencer.sv
// fp_simd_sequencer: queues tagged commands and drives the fp_simd ALU
// one operation at a time, returning each result over a ready/valid port.
module fp_simd_sequencer #(
  parameter int SIMD_WIDTH = 4,
  parameter int CMD_DEPTH  = 2,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [2:0]               i_cmd_opcode,
  input  logic [SIMD_WIDTH*22-1:0] i_cmd_a,
  input  logic [SIMD_WIDTH*22-1:0] i_cmd_b,
  input  logic [TAG_W-1:0]         i_cmd_tag,
  output logic                     o_simd_en,
  output logic [2:0]               o_simd_opcode,
  output logic [SIMD_WIDTH*22-1:0] o_simd_in1,
  output logic [SIMD_WIDTH*22-1:0] o_simd_in2,
  input  logic                     i_simd_busy,
  input  logic                     i_simd_valid,
  input  logic [SIMD_WIDTH*22-1:0] i_simd_output,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [SIMD_WIDTH*22-1:0] o_res_data,
  output logic [TAG_W-1:0]         o_res_tag,
  output logic                     o_res_err,
  output logic                     o_err_timeout,
  output logic                     o_idle
);
  localparam int DW = SIMD_WIDTH * 22;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam int EW = 3 + 2 * DW + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    fifo_mem [CMD_DEPTH];
  logic [EW-1:0]    head;
  logic [WW-1:0]    wd_q, wd_d;
  logic [2:0]       op_q, op_d;
  logic [DW-1:0]    in1_q, in1_d;
  logic [DW-1:0]    in2_q, in2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [DW-1:0]    res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;
  logic             err_to_q, err_to_d;
  logic             empty, full, push, pop;

  always_comb begin
    empty = (count_q == '0);
    full = (count_q == CW'(CMD_DEPTH));
    pop = (state_q == S_IDLE) && !empty && !i_simd_busy;
    o_cmd_ready = !full || pop;
    push = i_cmd_valid && o_cmd_ready;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    head = fifo_mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {i_cmd_opcode, i_cmd_a, i_cmd_b, i_cmd_tag};
    end
  end

  // Watchdog starts at the pop so that the issue cycle counts as cycle 0.
  always_comb begin
    state_d = state_q;
    wd_d = wd_q;
    op_d = op_q;
    in1_d = in1_q;
    in2_d = in2_q;
    tag_d = tag_q;
    res_data_d = res_data_q;
    res_tag_d = res_tag_q;
    res_err_d = res_err_q;
    err_to_d = err_to_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          {op_d, in1_d, in2_d, tag_d} = head;
          wd_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d = wd_q + WW'(1);
        state_d = (op_q[2:1] == 2'b11) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WW'(1);
        if (i_simd_valid) begin
          res_data_d = i_simd_output;
          res_tag_d = tag_q;
          res_err_d = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          res_data_d = '0;
          res_tag_d = tag_q;
          res_err_d = 1'b1;
          err_to_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      wd_q <= '0;
      op_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      tag_q <= '0;
      res_data_q <= '0;
      res_tag_q <= '0;
      res_err_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      wd_q <= wd_d;
      op_q <= op_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      tag_q <= tag_d;
      res_data_q <= res_data_d;
      res_tag_q <= res_tag_d;
      res_err_q <= res_err_d;
      err_to_q <= err_to_d;
    end
  end

  assign o_simd_en = (state_q == S_ISSUE);
  assign o_simd_opcode = op_q;
  assign o_simd_in1 = in1_q;
  assign o_simd_in2 = in2_q;
  assign o_res_valid = (state_q == S_RESP);
  assign o_res_data = res_data_q;
  assign o_res_tag = res_tag_q;
  assign o_res_err = res_err_q;
  assign o_err_timeout = err_to_q;
  assign o_idle = empty && (state_q == S_IDLE);
endmodule
